// File: rtl/wb_arbiter2_pkg.sv
// Shared bus widths and arbiter state encoding for the external Wishbone port.
package kcp_bus_pkg;
  localparam int ADR_W = 64;
  localparam int DAT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_ABORT = 2'd3
  } state_e;
endpackage

// File: rtl/wb_arbiter2_if.sv
// Bundle of both requester ports plus the external Wishbone master port.
// The slave modport is the arbiter's view; master is the surrounding core/bus.
interface wb_arbiter2_if;
  import kcp_bus_pkg::*;

  logic [ADR_W-1:0] m0adr_i, m1adr_i, wbmadr_o;
  logic [DAT_W-1:0] m0dat_i, m1dat_i, wbmdat_o;
  logic             m0we_i, m0stb_i, m0cyc_i;
  logic             m1we_i, m1stb_i, m1cyc_i;
  logic             m0ack_o, m0err_o, m1ack_o, m1err_o;
  logic [DAT_W-1:0] m0dat_o, m1dat_o, wbmdat_i;
  logic             wbmwe_o, wbmstb_o, wbmcyc_o, wbmack_i;

  modport slave (
    input  m0adr_i, m0dat_i, m0we_i, m0stb_i, m0cyc_i,
    input  m1adr_i, m1dat_i, m1we_i, m1stb_i, m1cyc_i,
    input  wbmack_i, wbmdat_i,
    output m0ack_o, m0err_o, m0dat_o, m1ack_o, m1err_o, m1dat_o,
    output wbmadr_o, wbmdat_o, wbmwe_o, wbmstb_o, wbmcyc_o
  );

  modport master (
    output m0adr_i, m0dat_i, m0we_i, m0stb_i, m0cyc_i,
    output m1adr_i, m1dat_i, m1we_i, m1stb_i, m1cyc_i,
    output wbmack_i, wbmdat_i,
    input  m0ack_o, m0err_o, m0dat_o, m1ack_o, m1err_o, m1dat_o,
    input  wbmadr_o, wbmdat_o, wbmwe_o, wbmstb_o, wbmcyc_o
  );
endinterface

// File: rtl/wb_arbiter2_watchdog.sv
// Bus-timeout counter: counts strobe-without-ack cycles and flags the cycle
// in which the count reaches TIMEOUT-1 with the strobe still unanswered.
module wb_watchdog #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr,
  input  logic tick,
  output logic expire
);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = tick & ~clr & (cnt_q == LAST);

  // Next count: clear on request or on expiry, otherwise advance on tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || expire)  cnt_d = '0;
    else if (tick)      cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/wb_arbiter2.sv
// Two-requester Wishbone arbiter: whole-cycle grants, round-robin on ties,
// one mandatory idle cycle between owners, and a watchdog abort for hung slaves.
module wb_arbiter2
  import kcp_bus_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  wb_arbiter2_if.slave  bus
);
  state_e state_q, state_d;
  logic   last_q, last_d;   // last granted requester; also the owner while in ABORT
  logic   own0, own1, own_stb, tick, clr, expire, own_cyc_abort;

  assign own0    = (state_q == ST_OWN0);
  assign own1    = (state_q == ST_OWN1);
  assign own_stb = own0 ? bus.m0stb_i : (own1 ? bus.m1stb_i : 1'b0);
  assign tick    = own_stb & ~bus.wbmack_i;
  assign clr     = ~tick;
  assign own_cyc_abort = last_q ? bus.m1cyc_i : bus.m0cyc_i;

  wb_watchdog #(.TIMEOUT(TIMEOUT), .CW(CW)) u_wdog (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr     (clr),
    .tick    (tick),
    .expire  (expire)
  );

  // Bus and requester outputs: pass-through for the owner, zero otherwise.
  always_comb begin
    bus.wbmadr_o = '0;
    bus.wbmdat_o = '0;
    bus.wbmwe_o  = 1'b0;
    bus.wbmstb_o = 1'b0;
    bus.wbmcyc_o = 1'b0;
    bus.m0ack_o  = 1'b0;
    bus.m0err_o  = 1'b0;
    bus.m0dat_o  = '0;
    bus.m1ack_o  = 1'b0;
    bus.m1err_o  = 1'b0;
    bus.m1dat_o  = '0;
    if (own0) begin
      bus.wbmadr_o = bus.m0adr_i;
      bus.wbmdat_o = bus.m0dat_i;
      bus.wbmwe_o  = bus.m0we_i;
      bus.wbmstb_o = bus.m0stb_i;
      bus.wbmcyc_o = bus.m0cyc_i;
      bus.m0ack_o  = bus.wbmack_i;
      bus.m0dat_o  = bus.wbmdat_i;
      bus.m0err_o  = expire;
    end else if (own1) begin
      bus.wbmadr_o = bus.m1adr_i;
      bus.wbmdat_o = bus.m1dat_i;
      bus.wbmwe_o  = bus.m1we_i;
      bus.wbmstb_o = bus.m1stb_i;
      bus.wbmcyc_o = bus.m1cyc_i;
      bus.m1ack_o  = bus.wbmack_i;
      bus.m1dat_o  = bus.wbmdat_i;
      bus.m1err_o  = expire;
    end
  end

  // Grant sequencing; expiry wins over the owner dropping cyc in the same cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.m0cyc_i && bus.m1cyc_i) begin
          state_d = last_q ? ST_OWN0 : ST_OWN1;
          last_d  = ~last_q;
        end else if (bus.m0cyc_i) begin
          state_d = ST_OWN0;
          last_d  = 1'b0;
        end else if (bus.m1cyc_i) begin
          state_d = ST_OWN1;
          last_d  = 1'b1;
        end
      end
      ST_OWN0: begin
        if (expire)            state_d = ST_ABORT;
        else if (!bus.m0cyc_i) state_d = ST_IDLE;
      end
      ST_OWN1: begin
        if (expire)            state_d = ST_ABORT;
        else if (!bus.m1cyc_i) state_d = ST_IDLE;
      end
      ST_ABORT: begin
        if (!own_cyc_abort) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant state registers; last starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: a per-cycle vector table for the grant and
// pass-through paths, plus hand sequences for round-robin, timeout and reset.
module tb_wb_arbiter2;
  localparam logic [63:0] A0 = 64'h1000, A1 = 64'h2000;
  localparam logic [15:0] W0 = 16'h5555, W1 = 16'h1234, RD = 16'hBEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter2_if bus();

  wb_arbiter2 #(.TIMEOUT(16), .CW(8)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic c0, s0, c1, s1, ack;
    logic bcyc, bstb;
    logic [63:0] adr;
    logic we;
    logic [15:0] wdat;
    logic a0, a1;
    logic [15:0] d0, d1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic c0, s0, c1, s1, ack, bcyc, bstb,
                              logic [63:0] adr, logic we, logic [15:0] wdat,
                              logic a0, a1, logic [15:0] d0, d1);
    vec_t v;
    v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack;
    v.bcyc = bcyc; v.bstb = bstb; v.adr = adr; v.we = we; v.wdat = wdat;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic c0, s0, c1, s1, ack);
    bus.m0cyc_i = c0; bus.m0stb_i = s0;
    bus.m1cyc_i = c1; bus.m1stb_i = s1;
    bus.wbmack_i = ack;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cyc", bus.wbmcyc_o, 0);
    chk("rst_adr", bus.wbmadr_o, 0);
    chk("rst_ack", {bus.m0ack_o, bus.m1ack_o, bus.m0err_o, bus.m1err_o}, 0);
    rst = 1'b0;
  endtask

  task automatic step(logic c0, s0, c1, s1, ack);
    @(posedge clk); #1;
    drive(c0, s0, c1, s1, ack);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int g[$];
    logic drop0, drop1;

    bus.m0adr_i = A0; bus.m0dat_i = W0; bus.m0we_i = 1'b0;
    bus.m1adr_i = A1; bus.m1dat_i = W1; bus.m1we_i = 1'b1;
    bus.wbmdat_i = RD;
    drive(0, 0, 0, 0, 0);

    // tie after reset: m0 first, idle gap, then m1 write
    tbl.push_back(mk(1,1,1,1,0, 0,0,0,0,0,    0,0,0,0));
    tbl.push_back(mk(1,1,1,1,1, 1,1,A0,0,W0,  1,0,RD,0));
    tbl.push_back(mk(0,0,1,1,0, 0,0,A0,0,W0,  0,0,RD,0));
    tbl.push_back(mk(0,0,1,1,0, 0,0,0,0,0,    0,0,0,0));
    tbl.push_back(mk(0,0,1,1,1, 1,1,A1,1,W1,  0,1,0,RD));
    tbl.push_back(mk(0,0,0,0,0, 0,0,A1,1,W1,  0,0,0,RD));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,    0,0,0,0));
    // single m0 read, ack on third bus cycle
    tbl.push_back(mk(1,1,0,0,0, 0,0,0,0,0,    0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0, 1,1,A0,0,W0,  0,0,RD,0));
    tbl.push_back(mk(1,1,0,0,0, 1,1,A0,0,W0,  0,0,RD,0));
    tbl.push_back(mk(1,1,0,0,1, 1,1,A0,0,W0,  1,0,RD,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,A0,0,W0,  0,0,RD,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,    0,0,0,0));

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1, tbl[i].ack);
      chk($sformatf("v%0d_cyc", i), bus.wbmcyc_o, tbl[i].bcyc);
      chk($sformatf("v%0d_stb", i), bus.wbmstb_o, tbl[i].bstb);
      chk($sformatf("v%0d_adr", i), bus.wbmadr_o, tbl[i].adr);
      chk($sformatf("v%0d_we", i), bus.wbmwe_o, tbl[i].we);
      chk($sformatf("v%0d_wdat", i), bus.wbmdat_o, tbl[i].wdat);
      chk($sformatf("v%0d_ack", i), {bus.m0ack_o, bus.m1ack_o}, {tbl[i].a0, tbl[i].a1});
      chk($sformatf("v%0d_err", i), {bus.m0err_o, bus.m1err_o}, 0);
      chk($sformatf("v%0d_d0", i), bus.m0dat_o, tbl[i].d0);
      chk($sformatf("v%0d_d1", i), bus.m1dat_o, tbl[i].d1);
    end

    // round-robin: both hold cyc, drop for one clock after each ack
    do_reset();
    drop0 = 1'b0; drop1 = 1'b0;
    for (int c = 0; c < 60 && g.size() < 4; c++) begin
      @(posedge clk); #1;
      drive(~drop0, ~drop0, ~drop1, ~drop1, 0);
      #1 bus.wbmack_i = bus.wbmcyc_o & bus.wbmstb_o;
      @(negedge clk);
      if (bus.m0ack_o) g.push_back(0);
      if (bus.m1ack_o) g.push_back(1);
      drop0 = bus.m0ack_o;
      drop1 = bus.m1ack_o;
    end
    drive(0, 0, 0, 0, 0);
    chk("rr_count", g.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant%0d", i), (i < g.size()) ? g[i] : 9, i % 2);

    // timeout: no ack, err in strobe cycle 16, abort, late ack ignored
    do_reset();
    step(1, 1, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      step(1, 1, 0, 0, 0);
      chk($sformatf("to_err_k%0d", k), bus.m0err_o, (k == 16));
      chk($sformatf("to_cyc_k%0d", k), bus.wbmcyc_o, 1);
    end
    step(1, 1, 0, 0, 1);
    chk("to_abort_cyc", {bus.wbmcyc_o, bus.wbmstb_o}, 0);
    chk("to_abort_adr", bus.wbmadr_o, 0);
    chk("to_late_ack", {bus.m0ack_o, bus.m0err_o}, 0);
    step(1, 1, 0, 0, 0);
    chk("to_abort_hold", bus.wbmcyc_o, 0);
    step(0, 0, 0, 0, 0);
    chk("to_abort_drop", bus.wbmcyc_o, 0);
    step(0, 0, 1, 1, 0);
    chk("to_idle", bus.wbmcyc_o, 0);
    step(0, 0, 1, 1, 0);
    chk("to_regrant_cyc", bus.wbmcyc_o, 1);
    chk("to_regrant_adr", bus.wbmadr_o, A1);
    step(0, 0, 0, 0, 0);

    // ack exactly in strobe cycle 16 is a normal ack
    do_reset();
    step(1, 1, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      step(1, 1, 0, 0, (k == 16));
      chk($sformatf("bd_err_k%0d", k), bus.m0err_o, 0);
    end
    chk("bd_ack", bus.m0ack_o, 1);
    step(1, 1, 0, 0, 0);
    chk("bd_no_abort", bus.wbmcyc_o, 1);
    chk("bd_no_err", bus.m0err_o, 0);
    step(0, 0, 0, 0, 0);

    // asynchronous reset in the middle of an m1 transfer
    do_reset();
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    chk("mr_own1", bus.wbmcyc_o, 1);
    @(posedge clk); #1;
    bus.wbmack_i = 1'b1;
    #1 chk("mr_pre_ack", bus.m1ack_o, 1);
    #1 rst = 1'b1;
    #1;
    chk("mr_cyc", bus.wbmcyc_o, 0);
    chk("mr_stb", bus.wbmstb_o, 0);
    chk("mr_ack", bus.m1ack_o, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    chk("mr_tie_cyc", bus.wbmcyc_o, 1);
    chk("mr_tie_adr", bus.wbmadr_o, A0);
    step(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
